// File: rtl/trap_entry_sequencer_if.sv
// Handshake and CSR-state bundle between the exception encoder / retire stage and the trap sequencer.
// The sequencer connects as the slave; upstream logic drives the master side.
interface trap_entry_sequencer_if #(
   parameter int XLEN = 32
);
   logic            except_valid;
   logic            except_ready;
   logic [XLEN-1:0] except_cause;
   logic [XLEN-1:0] except_epc;
   logic [XLEN-1:0] except_tval;
   logic [XLEN-1:0] mtvec_in;
   logic            mret_valid;
   logic            mret_ready;
   logic            flush_out;
   logic            csr_we;
   logic [XLEN-1:0] mepc_out;
   logic [XLEN-1:0] mcause_out;
   logic [XLEN-1:0] mtval_out;
   logic [XLEN-1:0] mstatus_out;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            busy;

   modport master (
      output except_valid, except_cause, except_epc, except_tval, mtvec_in, mret_valid,
      input  except_ready, mret_ready, flush_out, csr_we, mepc_out, mcause_out,
             mtval_out, mstatus_out, redirect_valid, redirect_pc, busy
   );

   modport slave (
      input  except_valid, except_cause, except_epc, except_tval, mtvec_in, mret_valid,
      output except_ready, mret_ready, flush_out, csr_we, mepc_out, mcause_out,
             mtval_out, mstatus_out, redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/trap_entry_sequencer.sv
// M-mode trap entry and MRET sequencer; owns mstatus/mepc/mcause/mtval.
//
// state      | meaning
// IDLE       | ready for an exception or MRET
// FLUSH      | flush_out held high, down-counter runs to zero
// COMMIT     | csr_we strobe, trap CSRs written at end of cycle
// REDIRECT   | redirect_valid strobe to the trap vector
// MRET_UPD   | mstatus restored at end of cycle
// MRET_REDIR | redirect_valid strobe to mepc
module trap_entry_sequencer #(
   parameter int              XLEN         = 32,
   parameter int              FLUSH_CYCLES = 2,
   parameter logic [XLEN-1:0] MSTATUS_RST  = 32'h0000_1800
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   trap_entry_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      COMMIT,
      REDIRECT,
      MRET_UPD,
      MRET_REDIR
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t          state_q, state_d;
   logic [3:0]      flush_cnt_q, flush_cnt_d;
   logic            accept_exc;

   logic [XLEN-1:0] cause_q, epc_q, tval_q, mtvec_q;
   logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, mstatus_q;
   logic            flush_q, csr_we_q, redir_v_q;
   logic [XLEN-1:0] redir_pc_q;

   logic [XLEN-1:0] trap_base, trap_target;
   logic [XLEN-1:0] mstatus_commit, mstatus_mret;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      accept_exc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.except_valid) begin
               accept_exc  = 1'b1;
               state_d     = FLUSH;
               flush_cnt_d = CNT_LOAD;
            end else if (bus.mret_valid) begin
               state_d = MRET_UPD;
            end
         end
         FLUSH: begin
            if (flush_cnt_q == '0) state_d = COMMIT;
            else                   flush_cnt_d = flush_cnt_q - 4'd1;
         end
         COMMIT:     state_d = REDIRECT;
         REDIRECT:   state_d = IDLE;
         MRET_UPD:   state_d = MRET_REDIR;
         MRET_REDIR: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Vectored offset is cause<<2 truncated to XLEN, so the add wraps naturally.
   always_comb begin
      trap_base = {mtvec_q[XLEN-1:2], 2'b00};
      if (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1])
         trap_target = trap_base + {cause_q[XLEN-3:0], 2'b00};
      else
         trap_target = trap_base;
   end

   always_comb begin
      mstatus_commit        = mstatus_q;
      mstatus_commit[7]     = mstatus_q[3];
      mstatus_commit[3]     = 1'b0;
      mstatus_commit[12:11] = 2'b11;
      mstatus_mret          = mstatus_q;
      mstatus_mret[3]       = mstatus_q[7];
      mstatus_mret[7]       = 1'b1;
      mstatus_mret[12:11]   = 2'b11;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cause_q    <= '0;
         epc_q      <= '0;
         tval_q     <= '0;
         mtvec_q    <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mstatus_q  <= MSTATUS_RST;
         flush_q    <= 1'b0;
         csr_we_q   <= 1'b0;
         redir_v_q  <= 1'b0;
         redir_pc_q <= '0;
      end else begin
         flush_q   <= (state_d == FLUSH);
         csr_we_q  <= (state_d == COMMIT);
         redir_v_q <= (state_d == REDIRECT) || (state_d == MRET_REDIR);
         if (accept_exc) begin
            cause_q <= bus.except_cause;
            epc_q   <= {bus.except_epc[XLEN-1:2], 2'b00};
            tval_q  <= bus.except_tval;
            mtvec_q <= bus.mtvec_in;
         end
         if (state_q == COMMIT) begin
            mepc_q     <= epc_q;
            mcause_q   <= cause_q;
            mtval_q    <= tval_q;
            mstatus_q  <= mstatus_commit;
            redir_pc_q <= trap_target;
         end
         if (state_q == MRET_UPD) begin
            mstatus_q  <= mstatus_mret;
            redir_pc_q <= mepc_q;
         end
      end
   end

   assign bus.except_ready   = (state_q == IDLE);
   assign bus.mret_ready     = (state_q == IDLE) && !bus.except_valid;
   assign bus.busy           = (state_q != IDLE);
   assign bus.flush_out      = flush_q;
   assign bus.csr_we         = csr_we_q;
   assign bus.redirect_valid = redir_v_q;
   assign bus.redirect_pc    = redir_pc_q;
   assign bus.mepc_out       = mepc_q;
   assign bus.mcause_out     = mcause_q;
   assign bus.mtval_out      = mtval_q;
   assign bus.mstatus_out    = mstatus_q;

endmodule

// File: tb/tb_trap_entry_sequencer.sv
// Bench for trap_entry_sequencer: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model that tracks each accepted operation by its cycle offset.
module tb_trap_entry_sequencer;
   localparam int          XLEN   = 32;
   localparam int          FC     = 2;
   localparam logic [31:0] MS_RST = 32'h0000_1800;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;

   trap_entry_sequencer_if #(.XLEN(XLEN)) bus ();

   trap_entry_sequencer #(
      .XLEN(XLEN),
      .FLUSH_CYCLES(FC),
      .MSTATUS_RST(MS_RST)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .bus(bus)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // upstream stimulus, held while pending
   logic        rst_v, e_v, m_v;
   logic [31:0] e_cause, e_epc, e_tval, e_mtvec;

   // reference model
   int          op_kind;   // 0 none, 1 exception, 2 mret
   int          op_start;
   logic [31:0] h_cause, h_epc, h_tval, h_mtvec;
   logic [31:0] m_mepc, m_mcause, m_mtval, m_mstatus, m_rpc;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int k_now();
      return cyc - op_start;
   endfunction

   function automatic bit m_idle();
      if (op_kind == 1) return k_now() >= FC + 3;
      if (op_kind == 2) return k_now() >= 3;
      return 1'b1;
   endfunction

   task automatic model_reset();
      op_kind   = 0;
      op_start  = 0;
      m_mepc    = 32'h0;
      m_mcause  = 32'h0;
      m_mtval   = 32'h0;
      m_mstatus = MS_RST;
      m_rpc     = 32'h0;
   endtask

   task automatic model_commit();
      logic mie;
      mie               = m_mstatus[3];
      m_mepc            = h_epc & 32'hFFFF_FFFC;
      m_mcause          = h_cause;
      m_mtval           = h_tval;
      m_mstatus[7]      = mie;
      m_mstatus[3]      = 1'b0;
      m_mstatus[12:11]  = 2'b11;
      if (h_mtvec[1:0] == 2'b01 && h_cause[31])
         m_rpc = (h_mtvec & 32'hFFFF_FFFC) + (h_cause & 32'h7FFF_FFFF) * 32'd4;
      else
         m_rpc = h_mtvec & 32'hFFFF_FFFC;
   endtask

   task automatic model_mret();
      m_mstatus[3]     = m_mstatus[7];
      m_mstatus[7]     = 1'b1;
      m_mstatus[12:11] = 2'b11;
      m_rpc            = m_mepc;
   endtask

   task automatic step();
      bit acc_e, acc_m;
      int k;
      @(negedge clk_in);
      k = k_now();
      check_val("flush_out", 32'(bus.flush_out), 32'(op_kind == 1 && k >= 1 && k <= FC));
      check_val("csr_we", 32'(bus.csr_we), 32'(op_kind == 1 && k == FC + 1));
      check_val("redirect_valid", 32'(bus.redirect_valid),
                32'((op_kind == 1 && k == FC + 2) || (op_kind == 2 && k == 2)));
      check_val("busy", 32'(bus.busy), 32'(!m_idle()));
      check_val("redirect_pc", bus.redirect_pc, m_rpc);
      check_val("mepc", bus.mepc_out, m_mepc);
      check_val("mcause", bus.mcause_out, m_mcause);
      check_val("mtval", bus.mtval_out, m_mtval);
      check_val("mstatus", bus.mstatus_out, m_mstatus);
      rst_in           = rst_v;
      bus.except_valid = e_v;
      bus.except_cause = e_cause;
      bus.except_epc   = e_epc;
      bus.except_tval  = e_tval;
      bus.mtvec_in     = e_mtvec;
      bus.mret_valid   = m_v;
      #1;
      check_val("except_ready", 32'(bus.except_ready), 32'(m_idle()));
      check_val("mret_ready", 32'(bus.mret_ready), 32'(m_idle() && !e_v));
      acc_e = rst_v && m_idle() && e_v;
      acc_m = rst_v && m_idle() && m_v && !e_v;
      @(posedge clk_in);
      if (!rst_v) begin
         model_reset();
      end else begin
         if (op_kind == 1 && k == FC + 1) model_commit();
         if (op_kind == 2 && k == 1) model_mret();
         if (acc_e) begin
            op_kind  = 1;
            op_start = cyc;
            h_cause  = e_cause;
            h_epc    = e_epc;
            h_tval   = e_tval;
            h_mtvec  = e_mtvec;
            e_v      = 1'b0;
         end
         if (acc_m) begin
            op_kind  = 2;
            op_start = cyc;
            m_v      = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic run_to_idle();
      int n = 0;
      while (!m_idle() && n < 50) begin
         step();
         n++;
      end
      #1 check_val("idle_bound", 32'(bus.busy), 32'h0);
   endtask

   task automatic wait_exc();
      int n = 0;
      while (e_v && n < 50) begin
         step();
         n++;
      end
   endtask

   task automatic do_mret();
      m_v = 1'b1;
      while (m_v) step();
      run_to_idle();
   endtask

   task automatic set_exc(input logic [31:0] c, input logic [31:0] p,
                          input logic [31:0] t, input logic [31:0] v);
      e_v     = 1'b1;
      e_cause = c;
      e_epc   = p;
      e_tval  = t;
      e_mtvec = v;
   endtask

   initial begin
      rst_v   = 1'b0;
      e_v     = 1'b0;
      m_v     = 1'b0;
      e_cause = '0;
      e_epc   = '0;
      e_tval  = '0;
      e_mtvec = '0;
      bus.except_valid = 1'b0;
      bus.except_cause = '0;
      bus.except_epc   = '0;
      bus.except_tval  = '0;
      bus.mtvec_in     = '0;
      bus.mret_valid   = 1'b0;
      repeat (2) @(posedge clk_in);
      model_reset();
      step();
      rst_v = 1'b1;
      #1;
      check_val("rst_mstatus", bus.mstatus_out, 32'h0000_1800);
      check_val("rst_mepc", bus.mepc_out, 32'h0);
      check_val("rst_ready", 32'(bus.except_ready), 32'h1);

      // two MRETs raise MIE so the trap entry has something to stack
      do_mret();
      do_mret();
      #1 check_val("mie_set", bus.mstatus_out, 32'h0000_1888);

      // direct-mode synchronous exception
      set_exc(32'd2, 32'h0000_1236, 32'hDEAD_BEEF, 32'h8000_0101);
      wait_exc();
      run_to_idle();
      #1;
      check_val("direct_mepc", bus.mepc_out, 32'h0000_1234);
      check_val("direct_mcause", bus.mcause_out, 32'd2);
      check_val("direct_mtval", bus.mtval_out, 32'hDEAD_BEEF);
      check_val("direct_mstatus", bus.mstatus_out, 32'h0000_1880);
      check_val("direct_pc", bus.redirect_pc, 32'h8000_0100);

      // MRET back to mepc
      do_mret();
      #1;
      check_val("mret_mstatus", bus.mstatus_out, 32'h0000_1888);
      check_val("mret_pc", bus.redirect_pc, 32'h0000_1234);

      // vectored interrupt
      set_exc(32'h8000_0007, 32'h0000_4000, 32'h0, 32'h8000_0001);
      wait_exc();
      run_to_idle();
      #1 check_val("vector_pc", bus.redirect_pc, 32'h8000_001C);

      // exception and MRET together: exception first, MRET right after REDIRECT
      set_exc(32'd11, 32'h0000_2000, 32'h5, 32'h0000_0300);
      m_v = 1'b1;
      wait_exc();
      run_to_idle();
      step();
      #1 check_val("held_mret_taken", 32'(bus.busy), 32'h1);
      run_to_idle();

      // new exception raised during FLUSH waits for IDLE
      set_exc(32'd4, 32'h0000_3000, 32'h6, 32'h0000_0400);
      wait_exc();
      step();
      set_exc(32'd5, 32'h0000_3104, 32'h7, 32'h0000_0500);
      run_to_idle();
      wait_exc();
      run_to_idle();

      // reset during FLUSH aborts the sequence
      set_exc(32'd6, 32'h0000_5000, 32'h8, 32'h0000_0600);
      wait_exc();
      step();
      rst_v = 1'b0;
      step();
      rst_v = 1'b1;
      #1;
      check_val("abort_mepc", bus.mepc_out, 32'h0);
      check_val("abort_mstatus", bus.mstatus_out, 32'h0000_1800);
      repeat (FC + 3) step();

      // wrapping vectored target
      set_exc(32'hFFFF_FFFF, 32'h0000_6000, 32'h9, 32'hFFFF_FFFD);
      wait_exc();
      run_to_idle();
      #1 check_val("wrap_pc", bus.redirect_pc, 32'hFFFF_FFF8);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (!e_v && $urandom_range(0, 3) == 0) begin
            logic [31:0] c, v;
            c = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            c[31] = 1'($urandom_range(0, 1));
            v = $urandom() & 32'hFFFF_FFFC;
            v = v | (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : 32'h1);
            set_exc(c, $urandom(), $urandom(), v);
         end
         if (!m_v && $urandom_range(0, 4) == 0) m_v = 1'b1;
         rst_v = ($urandom_range(0, 149) != 0);
         step();
      end
      rst_v = 1'b1;
      e_v   = 1'b0;
      m_v   = 1'b0;
      run_to_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/trap_entry_sequencer.md
Name: trap_entry_sequencer

Overview:
- Sits directly downstream of the exception encoder and consumes its selected highest-priority exception (cause, EPC, tval) plus the current mtvec.
- Sequences M-mode trap entry: pipeline flush, one-cycle CSR commit (mepc/mcause/mtval/mstatus), then PC redirect to the trap vector.
- Also sequences MRET: restores mstatus.MIE and redirects to mepc.
- Owns the architectural mstatus and mepc registers.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYCLES, 2, cycles flush_out is held high before the CSR commit; legal range 1..15.
- MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP=11, MIE=0, MPIE=0).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous reset, active-low
- except_valid  in  1  encoder presents an exception
- except_ready  out  1  sequencer accepts the exception this cycle
- except_cause  in  XLEN  mcause value; bit31 = interrupt
- except_epc  in  XLEN  faulting PC
- except_tval  in  XLEN  mtval value
- mtvec_in  in  XLEN  current mtvec CSR
- mret_valid  in  1  MRET retiring
- mret_ready  out  1  MRET accepted this cycle
- flush_out  out  1  pipeline flush request
- csr_we  out  1  one-cycle commit strobe for mepc/mcause/mtval/mstatus
- mepc_out  out  XLEN  architectural mepc
- mcause_out  out  XLEN  architectural mcause
- mtval_out  out  XLEN  architectural mtval
- mstatus_out  out  XLEN  architectural mstatus
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst_in==0 at a clk_in edge forces:
  - state=IDLE; mstatus_out=MSTATUS_RST.
  - mepc_out, mcause_out, mtval_out, redirect_pc = 0.
  - flush_out, csr_we, redirect_valid = 0.
- Reset mid-sequence aborts with no commit and no redirect.
- States:
  - IDLE
  - FLUSH: counter runs 0..FLUSH_CYCLES-1.
  - COMMIT: 1 cycle.
  - REDIRECT: 1 cycle.
  - MRET_UPD: 1 cycle.
  - MRET_REDIR: 1 cycle.
- except_ready = (state==IDLE). mret_ready = (state==IDLE) && !except_valid.
- Handshakes:
  - Transfer occurs on valid&&ready at the edge.
  - While not ready, upstream holds valid and its payload stable. The sequencer does not sample inputs outside the accept cycle.
- Exception accept (edge N):
  - Latch cause, epc, tval, mtvec into holding registers.
  - Go to FLUSH.
  - flush_out=1 in cycles N+1..N+FLUSH_CYCLES.
- COMMIT (cycle N+FLUSH_CYCLES+1): csr_we=1 for one cycle. Registers update at the end of COMMIT:
  - mepc <= {epc[XLEN-1:2],2'b00}.
  - mcause <= cause. mtval <= tval.
  - mstatus.MPIE(bit7) <= MIE(bit3). MIE <= 0. MPP(12:11) <= 2'b11.
  - All other mstatus bits unchanged.
- REDIRECT (cycle N+FLUSH_CYCLES+2): redirect_valid=1.
  - base = {mtvec[XLEN-1:2],2'b00}.
  - If mtvec[1:0]==2'b01 and cause[XLEN-1]==1: redirect_pc = base + (cause[XLEN-2:0] << 2), modulo 2^XLEN (wraps).
  - Otherwise (direct mode, synchronous exception, or reserved modes 10/11): redirect_pc = base.
- After REDIRECT, return to IDLE. The next accept is possible in the following cycle.
- MRET accept (edge M) goes to MRET_UPD. At the end of MRET_UPD:
  - MIE <= MPIE. MPIE <= 1. MPP <= 2'b11 (machine-only core).
  - csr_we stays 0; mstatus_out updates internally.
- MRET_REDIR (cycle M+2): redirect_valid=1, redirect_pc=mepc_out, then IDLE. No flush on MRET.
- Simultaneous except_valid and mret_valid in IDLE: the exception wins and the MRET is not accepted; upstream holds it.
- Inputs arriving while busy are not accepted. There is no queueing; the encoder retains the pending exception.
- Outputs are registered. redirect_pc holds its last value when redirect_valid=0.
- mepc_out, mcause_out, mtval_out, mstatus_out change only at the COMMIT/MRET_UPD edges or on reset.

Test Plan:
1. Reset → all outputs 0 except mstatus_out=32'h1800. busy=0, except_ready=1, mret_ready=1.
2. Direct-mode exception:
   - Stimulus: FLUSH_CYCLES=2, mtvec=32'h8000_0101, cause=2, epc=32'h0000_1236, tval=32'hDEAD_BEEF, MIE=1, accepted at edge N.
   - Response: flush_out high N+1..N+2. csr_we at N+3, then mepc=32'h1234, mcause=2, mtval=32'hDEADBEEF, mstatus=32'h1880. redirect_valid at N+4 with redirect_pc=32'h8000_0100.
3. Vectored interrupt: mtvec=32'h8000_0001, cause=32'h8000_0007 → redirect_pc=32'h8000_001C.
4. MRET after scenario 2 (mstatus=32'h1880) → mstatus=32'h1888, no flush, redirect_valid at M+2 with redirect_pc=32'h1234.
5. Contention:
   - except_valid and mret_valid together in IDLE → exception sequence runs, mret_ready=0 throughout.
   - The held MRET is accepted the cycle after REDIRECT.
   - A new except_valid raised during FLUSH → except_ready=0 until IDLE.
6. rst_in=0 during FLUSH → no csr_we, no redirect_valid, all outputs at reset values next cycle. The vectored target for cause=32'hFFFF_FFFF with mtvec=32'hFFFF_FFFD wraps modulo 2^32 to 32'hFFFF_FFF8.
